pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM that sequences the RV32I datapath around the PC register block. It issues instruction fetches and data accesses over a req/ack handshake, and strobes the instruction register and register-file writeback. Once per instruction, in writeback, it drives the PC enable and PC opcode so the PC datapath advances, jumps or branches. The block sits between the instruction decoder and the PC/memory datapath; it contains no address arithmetic.

## Interface
- `XLEN`, 32, datapath width (carried for package consistency; no XLEN-wide ports)
- `MemTimeout`, 16, maximum request cycles allowed per fetch or data access before a fault; must be ≥ 2
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `i_start` in 1: leave IDLE and begin fetching
- `o_imem_req` out 1: instruction fetch request
- `i_imem_ack` in 1: instruction returned
- `o_ir_load` out 1: latch instruction register
- `i_instr_class` in `InstrClassW`: decoded class of the current instruction
- `i_branch_taken` in 1: branch comparison result, valid in EXECUTE
- `o_dmem_req` out 1: load/store request
- `i_dmem_ack` in 1: data access complete
- `o_rf_we` out 1: register-file write strobe
- `o_pc_en` out 1: PC update enable
- `o_pc_op` out `PcOps`: PC opcode
- `o_retire` out 1: one-cycle pulse per completed instruction
- `o_halted` out 1: sticky halt
- `o_fault` out 1: sticky fault
- `o_fault_cause` out 2: 0 none, 1 illegal, 2 imem timeout, 3 dmem timeout

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT.
- IDLE
  - `i_start` moves to FETCH.
  - `i_start` is ignored in every other state.
- FETCH
  - `o_imem_req` = 1.
  - On `i_imem_ack`: `o_ir_load` = 1 in the same cycle (Mealy), then go to DECODE.
- DECODE (1 cycle)
  - Register `i_instr_class` into `class_q`.
  - ClsIllegal goes to FAULT with cause 1.
  - ClsSystem (ecall/ebreak) goes to HALT.
  - All other classes go to EXECUTE.
- EXECUTE (1 cycle)
  - Register `i_branch_taken` into `taken_q`.
  - ClsLoad and ClsStore go to MEM; all other classes go to WRITEBACK.
- MEM
  - `o_dmem_req` = 1 until `i_dmem_ack`, then go to WRITEBACK.
- WRITEBACK (1 cycle)
  - `o_pc_en` = 1, `o_retire` = 1, then go to FETCH.
  - `o_pc_op` by class:
    - Alu, Load, Store: PcIncr
    - Jal: PcJAL
    - Jalr: PcJALR
    - Branch: PcBranch if `taken_q`, otherwise PcIncr
  - `o_rf_we` = 1 for Alu, Load, Jal and Jalr; 0 for Store and Branch.
- HALT: `o_halted` = 1. FAULT: `o_fault` = 1 and the cause is held. Both states are terminal until `rst`.
- Outside WRITEBACK: `o_pc_en` = 0 and `o_pc_op` = PcStop.
- Acks arriving outside FETCH or MEM are ignored.
- Timeout counter
  - Width `$clog2(MemTimeout)`.
  - Cleared on entry to FETCH or MEM; the first request cycle is count 0.
  - Increments on each request cycle with no ack.
  - An ack at count `MemTimeout-1` is still accepted; ack has priority over timeout.
  - No ack at count `MemTimeout-1` means the next state is FAULT with cause 2 (FETCH) or 3 (MEM).

## Timing
- Reset values: state IDLE; all 1-bit outputs 0; `o_pc_op` = PcStop; `o_fault_cause` = 0; counter 0; `class_q` = ClsAlu; `taken_q` = 0.
- `rst` in any state, including mid-request or HALT/FAULT, returns to IDLE on the next edge with the reset values above. Outstanding requests are dropped.
- All outputs are Moore decodes of state, except `o_ir_load` (FETCH & `i_imem_ack`).
- The PC updates at the WRITEBACK→FETCH edge, so the next FETCH presents the new address.
- Latency with zero-wait memory:
  - Alu, branch, jump: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK)
  - Load, store: 5 cycles
  - Each wait cycle adds 1.
- `o_imem_req` and `o_dmem_req` stay high continuously until ack or fault; they never drop early.

## Structure
- Add to `riscv_pkg`:
  - `InstrClassW` and the `instr_class_e` enum (ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsSystem, ClsIllegal)
  - `fault_cause_e`
  - `seq_state_e`
- Reuse the existing `PcOps` width and the PcStop/PcIncr/PcJAL/PcJALR/PcBranch encodings from `riscv_pkg`.
- One sub-module, `req_timeout`: counter with clear, increment and an `expired` output, instantiated once and shared by FETCH and MEM.

## Test plan
- Reset, `i_start`, zero-wait ALU instruction: `o_ir_load` in cycle 1; `o_pc_en` = 1 with PcIncr, `o_rf_we` = 1 and `o_retire` = 1 in cycle 4; FETCH re-enters in cycle 5.
- Branch with `i_branch_taken` = 1, then with 0: WRITEBACK `o_pc_op` = PcBranch, then PcIncr; `o_rf_we` = 0 both times.
- Load with `i_dmem_ack` delayed 3 cycles: `o_dmem_req` high for 4 consecutive cycles; retire in cycle 8; `o_rf_we` = 1.
- `MemTimeout` = 4 with no `i_imem_ack`: 4 request cycles, then FAULT with cause 2. Repeat with the ack on the 4th request cycle: accepted, no fault.
- ClsIllegal gives FAULT with cause 1; ClsSystem gives HALT. `o_pc_en` stays 0 for 10 further cycles; `i_start` has no effect.
- Assert `rst` during MEM wait and during HALT: next cycle IDLE, all outputs at reset values, `o_dmem_req` = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I types: PC opcodes, instruction classes, sequencer states and fault causes.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam int PcOps = 3;
    localparam logic [PcOps-1:0] PcStop   = 3'd0;
    localparam logic [PcOps-1:0] PcIncr   = 3'd1;
    localparam logic [PcOps-1:0] PcJAL    = 3'd2;
    localparam logic [PcOps-1:0] PcJALR   = 3'd3;
    localparam logic [PcOps-1:0] PcBranch = 3'd4;

    localparam int InstrClassW = 3;

    typedef enum logic [InstrClassW-1:0] {
        ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsSystem, ClsIllegal
    } instr_class_e;

    typedef enum logic [1:0] {
        FcNone, FcIllegal, FcImemTimeout, FcDmemTimeout
    } fault_cause_e;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMem, StWriteback, StHalt, StFault
    } seq_state_e;

endpackage

// File: rtl/req_timeout.sv
// Request-cycle counter shared by instruction fetch and data access.
// Latency: expired is a combinational decode of the count; holds at the limit, never wraps.
// Backpressure: none; clear wins over inc.
module req_timeout
    import riscv_pkg::*;
#(
    parameter int MemTimeout = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CntW = $clog2(MemTimeout);

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(MemTimeout - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (inc && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback around the PC block.
// Latency: 4 cycles per ALU/branch/jump, 5 per load/store, +1 per memory wait cycle.
// Backpressure: requests are held until ack or until the timeout faults the sequencer.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int MemTimeout = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    output logic                   o_imem_req,
    input  logic                   i_imem_ack,
    output logic                   o_ir_load,
    input  logic [InstrClassW-1:0] i_instr_class,
    input  logic                   i_branch_taken,
    output logic                   o_dmem_req,
    input  logic                   i_dmem_ack,
    output logic                   o_rf_we,
    output logic                   o_pc_en,
    output logic [PcOps-1:0]       o_pc_op,
    output logic                   o_retire,
    output logic                   o_halted,
    output logic                   o_fault,
    output logic [1:0]             o_fault_cause
);

    seq_state_e   state_q, state_d;
    instr_class_e class_q;
    instr_class_e class_in;
    logic         taken_q;
    fault_cause_e cause_q, cause_d;

    logic in_req;
    logic ack;
    logic tmo_expired;

    assign class_in = instr_class_e'(i_instr_class);
    assign in_req   = (state_q == StFetch) || (state_q == StMem);
    assign ack      = (state_q == StFetch) ? i_imem_ack : i_dmem_ack;

    // Counter is held at zero outside request states, so entry always starts at count 0.
    req_timeout #(.MemTimeout(MemTimeout)) u_req_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_req),
        .inc     (in_req && !ack),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            class_q <= ClsAlu;
            taken_q <= 1'b0;
            cause_q <= FcNone;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == StDecode) class_q <= class_in;
            if (state_q == StExecute) taken_q <= i_branch_taken;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StIdle:    if (i_start) state_d = StFetch;
            StFetch: begin
                if (i_imem_ack) begin
                    state_d = StDecode;
                end else if (tmo_expired) begin
                    state_d = StFault;
                    cause_d = FcImemTimeout;
                end
            end
            StDecode: begin
                if (class_in == ClsIllegal) begin
                    state_d = StFault;
                    cause_d = FcIllegal;
                end else if (class_in == ClsSystem) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: state_d = (class_q == ClsLoad || class_q == ClsStore) ? StMem : StWriteback;
            StMem: begin
                if (i_dmem_ack) begin
                    state_d = StWriteback;
                end else if (tmo_expired) begin
                    state_d = StFault;
                    cause_d = FcDmemTimeout;
                end
            end
            StWriteback: state_d = StFetch;
            default:     state_d = state_q;
        endcase
    end

    always_comb begin
        o_imem_req = (state_q == StFetch);
        o_ir_load  = (state_q == StFetch) && i_imem_ack;
        o_dmem_req = (state_q == StMem);
        o_halted   = (state_q == StHalt);
        o_fault    = (state_q == StFault);
        o_pc_en    = 1'b0;
        o_retire   = 1'b0;
        o_rf_we    = 1'b0;
        o_pc_op    = PcStop;
        if (state_q == StWriteback) begin
            o_pc_en  = 1'b1;
            o_retire = 1'b1;
            o_rf_we  = (class_q == ClsAlu) || (class_q == ClsLoad) ||
                       (class_q == ClsJal) || (class_q == ClsJalr);
            case (class_q)
                ClsJal:    o_pc_op = PcJAL;
                ClsJalr:   o_pc_op = PcJALR;
                ClsBranch: o_pc_op = taken_q ? PcBranch : PcIncr;
                default:   o_pc_op = PcIncr;
            endcase
        end
    end

    assign o_fault_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instructions push expected events, a monitor checks them.
module tb_pc_sequencer;
    import riscv_pkg::*;

    localparam int MemTimeout = 4;
    localparam int KRetire = 0, KHalt = 1, KFault = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   i_start = 1'b0;
    logic                   i_imem_ack = 1'b0;
    logic                   i_dmem_ack = 1'b0;
    logic                   i_branch_taken = 1'b0;
    logic [InstrClassW-1:0] i_instr_class = ClsAlu;
    logic                   o_imem_req, o_ir_load, o_dmem_req, o_rf_we, o_pc_en;
    logic                   o_retire, o_halted, o_fault;
    logic [PcOps-1:0]       o_pc_op;
    logic [1:0]             o_fault_cause;

    pc_sequencer #(.MemTimeout(MemTimeout)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .o_imem_req     (o_imem_req),
        .i_imem_ack     (i_imem_ack),
        .o_ir_load      (o_ir_load),
        .i_instr_class  (i_instr_class),
        .i_branch_taken (i_branch_taken),
        .o_dmem_req     (o_dmem_req),
        .i_dmem_ack     (i_dmem_ack),
        .o_rf_we        (o_rf_we),
        .o_pc_en        (o_pc_en),
        .o_pc_op        (o_pc_op),
        .o_retire       (o_retire),
        .o_halted       (o_halted),
        .o_fault        (o_fault),
        .o_fault_cause  (o_fault_cause)
    );

    always #5 clk = ~clk;

    // lat: cycles from first fetch cycle to the event cycle inclusive; ir: fetch cycle of ir_load (0 = none)
    typedef struct {
        int kind; int pc_op; int rf_we; int lat; int im; int dm; int ir; int cause;
    } exp_t;

    typedef struct {
        int cls; int tk; int iw; int dw; exp_t e;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int kind, input int op, input int we, input int lat,
                                input int im, input int dm, input int ir, input int cause);
        exp_t e;
        e.kind = kind; e.pc_op = op; e.rf_we = we; e.lat = lat;
        e.im = im; e.dm = dm; e.ir = ir; e.cause = cause;
        return e;
    endfunction

    function automatic vec_t mv(input int cls, input int tk, input int iw, input int dw, input exp_t e);
        vec_t v;
        v.cls = cls; v.tk = tk; v.iw = iw; v.dw = dw; v.e = e;
        return v;
    endfunction

    // Monitor: samples 2 time units after each falling edge, when inputs and outputs are settled.
    initial begin
        int   cyc, start_cyc, im, dm, ir_at;
        logic prev_imem, prev_flt, prev_halt, wb_pend, wb_rst;
        exp_t e;
        cyc = 0; start_cyc = 0; im = 0; dm = 0; ir_at = 0;
        prev_imem = 1'b0; prev_flt = 1'b0; prev_halt = 1'b0; wb_pend = 1'b0; wb_rst = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (wb_pend && !wb_rst) check("fetch_after_wb", o_imem_req, 1);
            if (o_imem_req && !prev_imem) begin
                start_cyc = cyc; im = 0; dm = 0; ir_at = 0;
            end
            if (o_imem_req) im++;
            if (o_dmem_req) dm++;
            if (o_ir_load) ir_at = cyc - start_cyc + 1;
            if (o_retire || (o_fault && !prev_flt) || (o_halted && !prev_halt)) begin
                check("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("event_kind", o_retire ? KRetire : (o_fault ? KFault : KHalt), e.kind);
                    check("event_latency", cyc - start_cyc + 1, e.lat);
                    check("imem_req_cycles", im, e.im);
                    check("dmem_req_cycles", dm, e.dm);
                    check("ir_load_cycle", ir_at, e.ir);
                    if (o_retire) begin
                        check("wb_pc_op", int'(o_pc_op), e.pc_op);
                        check("wb_rf_we", int'(o_rf_we), e.rf_we);
                        check("wb_pc_en", int'(o_pc_en), 1);
                    end else begin
                        check("term_cause", int'(o_fault_cause), e.cause);
                        check("term_pc_en", int'(o_pc_en), 0);
                    end
                end
            end
            wb_pend   = o_retire;
            wb_rst    = rst;
            prev_imem = o_imem_req;
            prev_flt  = o_fault;
            prev_halt = o_halted;
        end
    end

    task automatic check_reset_vals();
        check("rst_1bit_outputs",
              int'({o_imem_req, o_ir_load, o_dmem_req, o_rf_we, o_pc_en, o_retire, o_halted, o_fault}), 0);
        check("rst_pc_op", int'(o_pc_op), int'(PcStop));
        check("rst_fault_cause", int'(o_fault_cause), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_start = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", int'(o_imem_req), 0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // iw/dw: wait cycles before ack; negative means never ack.
    task automatic do_instr(input instr_class_e cls, input logic tk, input int iw, input int dw,
                            input bit push, input exp_t e);
        int n;
        n = 0;
        while (!o_imem_req && n < 20) begin @(negedge clk); n++; end
        check("imem_req_seen", int'(o_imem_req), 1);
        i_instr_class  = cls;
        i_branch_taken = tk;
        if (push) sb.push_back(e);
        if (iw < 0) return;
        repeat (iw) @(negedge clk);
        i_imem_ack = 1'b1;
        @(negedge clk);
        i_imem_ack = 1'b0;
        if ((cls == ClsLoad || cls == ClsStore) && dw >= 0) begin
            n = 0;
            while (!o_dmem_req && n < 20) begin @(negedge clk); n++; end
            check("dmem_req_seen", int'(o_dmem_req), 1);
            repeat (dw) @(negedge clk);
            i_dmem_ack = 1'b1;
            @(negedge clk);
            i_dmem_ack = 1'b0;
        end
    endtask

    task automatic wait_terminal();
        int n;
        n = 0;
        while (!(o_fault || o_halted) && n < 30) begin @(negedge clk); n++; end
        check("terminal_reached", int'(o_fault || o_halted), 1);
    endtask

    task automatic hold_terminal(input int halted, input int cause);
        for (int i = 0; i < 10; i++) begin
            i_start = (i % 2 == 0);
            @(negedge clk);
            check("terminal_pc_en", int'(o_pc_en), 0);
            check("terminal_no_fetch", int'(o_imem_req), 0);
            check("terminal_halted", int'(o_halted), halted);
            check("terminal_cause", int'(o_fault_cause), cause);
        end
        i_start = 1'b0;
    endtask

    vec_t vecs[9];
    exp_t none;

    initial begin
        none = mk(KRetire, 0, 0, 0, 0, 0, 0, 0);
        vecs[0] = mv(ClsAlu,    0,  0, 0, mk(KRetire, PcIncr,   1, 4, 1, 0, 1, 0));
        vecs[1] = mv(ClsBranch, 1,  0, 0, mk(KRetire, PcBranch, 0, 4, 1, 0, 1, 0));
        vecs[2] = mv(ClsBranch, 0,  0, 0, mk(KRetire, PcIncr,   0, 4, 1, 0, 1, 0));
        vecs[3] = mv(ClsJal,    0,  0, 0, mk(KRetire, PcJAL,    1, 4, 1, 0, 1, 0));
        vecs[4] = mv(ClsJalr,   0,  0, 0, mk(KRetire, PcJALR,   1, 4, 1, 0, 1, 0));
        vecs[5] = mv(ClsStore,  0,  0, 0, mk(KRetire, PcIncr,   0, 5, 1, 1, 1, 0));
        vecs[6] = mv(ClsLoad,   0,  0, 3, mk(KRetire, PcIncr,   1, 8, 1, 4, 1, 0));
        vecs[7] = mv(ClsAlu,    0,  3, 0, mk(KRetire, PcIncr,   1, 7, 4, 0, 4, 0));
        vecs[8] = mv(ClsAlu,    0, -1, 0, mk(KFault,  PcStop,   0, 5, 4, 0, 0, 2));

        @(negedge clk);
        do_reset();
        pulse_start();
        foreach (vecs[i])
            do_instr(instr_class_e'(vecs[i].cls), vecs[i].tk[0], vecs[i].iw, vecs[i].dw, 1'b1, vecs[i].e);
        wait_terminal();
        hold_terminal(0, 2);

        // Data-side timeout
        do_reset();
        pulse_start();
        do_instr(ClsLoad, 1'b0, 0, -1, 1'b1, mk(KFault, PcStop, 0, 8, 1, 4, 1, 3));
        wait_terminal();
        check("dmem_fault_cause", int'(o_fault_cause), 3);

        // Illegal instruction
        do_reset();
        pulse_start();
        do_instr(ClsIllegal, 1'b0, 0, 0, 1'b1, mk(KFault, PcStop, 0, 3, 1, 0, 1, 1));
        wait_terminal();
        hold_terminal(0, 1);

        // System instruction halts; reset out of HALT
        do_reset();
        pulse_start();
        do_instr(ClsSystem, 1'b0, 0, 0, 1'b1, mk(KHalt, PcStop, 0, 3, 1, 0, 1, 0));
        wait_terminal();
        hold_terminal(1, 0);
        do_reset();

        // Reset in the middle of a data wait
        pulse_start();
        do_instr(ClsLoad, 1'b0, 0, -1, 1'b0, none);
        begin
            int n;
            n = 0;
            while (!o_dmem_req && n < 20) begin @(negedge clk); n++; end
            check("mem_wait_reached", int'(o_dmem_req), 1);
        end
        @(negedge clk);
        do_reset();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
